// File: rtl/uart_dbg_bridge.sv
// UART debug bridge: turns READ/WRITE/EXEC command frames from a UART byte
// stream into single 32-bit OBI transfers or a core start pulse, and answers
// with ACK/NAK plus read data on the transmit stream.
module uart_dbg_bridge #(
    parameter int unsigned TimeoutCycles = 100000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        obi_req_o,
    output logic        obi_we_o,
    output logic [31:0] obi_addr_o,
    output logic [3:0]  obi_be_o,
    output logic [31:0] obi_wdata_o,
    input  logic        obi_gnt_i,
    input  logic        obi_rvalid_i,
    input  logic [31:0] obi_rdata_i,
    input  logic        obi_err_i,
    output logic [31:0] exec_addr_o,
    output logic        exec_valid_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        IDLE, ADDR, DATA, BUS_REQ, BUS_WAIT, RESP_CODE, RESP_DATA, EXEC
    } state_e;

    typedef enum logic [1:0] {CMD_READ, CMD_WRITE, CMD_EXEC} cmd_e;

    localparam logic [7:0]  ByteRead     = 8'h11;
    localparam logic [7:0]  ByteWrite    = 8'h12;
    localparam logic [7:0]  ByteExec     = 8'h13;
    localparam logic [7:0]  ByteAck      = 8'h06;
    localparam logic [7:0]  ByteNak      = 8'h15;
    localparam logic [31:0] TimeoutLimit = 32'(TimeoutCycles);

    state_e      state_q, state_d;
    cmd_e        cmd_q, cmd_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] exec_addr_q, exec_addr_d;
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic        err_q, err_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic        rx_fire;
    logic        in_field;
    logic        timeout_hit;

    assign in_field     = (state_q == ADDR) || (state_q == DATA);
    assign rx_ready_o   = (state_q == IDLE) || in_field;
    assign rx_fire      = rx_valid_i && rx_ready_o;
    assign tx_valid_o   = (state_q == RESP_CODE) || (state_q == RESP_DATA);
    assign obi_req_o    = (state_q == BUS_REQ);
    assign obi_we_o     = obi_req_o && (cmd_q == CMD_WRITE);
    assign obi_be_o     = obi_req_o ? 4'hF : 4'h0;
    assign obi_addr_o   = addr_q;
    assign obi_wdata_o  = wdata_q;
    assign exec_addr_o  = exec_addr_q;
    assign exec_valid_o = (state_q == EXEC);
    assign busy_o       = (state_q != IDLE);

    // A byte arriving in the same cycle as the timeout wins over the timeout.
    assign timeout_hit = (TimeoutCycles != 0) && in_field && !rx_fire
                         && (tmo_cnt_q >= TimeoutLimit);

    // Transmit byte: response code, then read data little-endian; zero otherwise.
    always_comb begin
        tx_data_o = 8'h00;
        if (state_q == RESP_CODE) begin
            tx_data_o = err_q ? ByteNak : ByteAck;
        end else if (state_q == RESP_DATA) begin
            tx_data_o = rdata_q[{byte_cnt_q, 3'b000} +: 8];
        end
    end

    // Next-state logic: frame decoding, bus sequencing and response sequencing.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        exec_addr_d = exec_addr_q;
        byte_cnt_d  = byte_cnt_q;
        case (state_q)
            IDLE: begin
                if (rx_fire && (rx_data_i == ByteRead || rx_data_i == ByteWrite
                                || rx_data_i == ByteExec)) begin
                    state_d = ADDR;
                    addr_d  = 32'h0;
                    wdata_d = 32'h0;
                    err_d   = 1'b0;
                    if (rx_data_i == ByteRead) begin
                        cmd_d = CMD_READ;
                    end else if (rx_data_i == ByteWrite) begin
                        cmd_d = CMD_WRITE;
                    end else begin
                        cmd_d = CMD_EXEC;
                    end
                end
            end
            ADDR: begin
                if (rx_fire) begin
                    addr_d[{byte_cnt_q, 3'b000} +: 8] = rx_data_i;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (cmd_q == CMD_WRITE) begin
                            state_d = DATA;
                        end else if (cmd_q == CMD_READ) begin
                            state_d = BUS_REQ;
                        end else begin
                            state_d     = EXEC;
                            exec_addr_d = addr_d;
                        end
                    end
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (rx_fire) begin
                    wdata_d[{byte_cnt_q, 3'b000} +: 8] = rx_data_i;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = BUS_REQ;
                    end
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            BUS_REQ: begin
                if (obi_gnt_i) begin
                    if (obi_rvalid_i) begin
                        rdata_d = obi_rdata_i;
                        err_d   = obi_err_i;
                        state_d = RESP_CODE;
                    end else begin
                        state_d = BUS_WAIT;
                    end
                end
            end
            BUS_WAIT: begin
                if (obi_rvalid_i) begin
                    rdata_d = obi_rdata_i;
                    err_d   = obi_err_i;
                    state_d = RESP_CODE;
                end
            end
            RESP_CODE: begin
                if (tx_ready_i) begin
                    state_d = (cmd_q == CMD_READ && !err_q) ? RESP_DATA : IDLE;
                end
            end
            RESP_DATA: begin
                if (tx_ready_i) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = IDLE;
                    end
                end
            end
            EXEC: begin
                state_d = RESP_CODE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (state_d != state_q) begin
            byte_cnt_d = 2'd0;
        end
    end

    // Inter-byte timeout counter: restarts on every byte or state change, saturates.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (rx_fire || state_d != state_q) begin
            tmo_cnt_d = 32'h0;
        end else if (in_field && tmo_cnt_q != 32'hFFFF_FFFF) begin
            tmo_cnt_d = tmo_cnt_q + 32'd1;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cmd_q       <= CMD_READ;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
            exec_addr_q <= 32'h0;
            byte_cnt_q  <= 2'd0;
            tmo_cnt_q   <= 32'h0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            exec_addr_q <= exec_addr_d;
            byte_cnt_q  <= byte_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_dbg_bridge.sv
// Scoreboard bench for uart_dbg_bridge: directed command frames push their
// expected tx bytes, OBI requests and exec pulses into queues, and monitors
// pop and compare whenever the DUT presents the matching output.
module tb_uart_dbg_bridge;

    typedef logic [7:0] byte_q_t[$];

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic        obi_req_o;
    logic        obi_we_o;
    logic [31:0] obi_addr_o;
    logic [3:0]  obi_be_o;
    logic [31:0] obi_wdata_o;
    logic        obi_gnt_i;
    logic        obi_rvalid_i;
    logic [31:0] obi_rdata_i;
    logic        obi_err_i;
    logic [31:0] exec_addr_o;
    logic        exec_valid_o;
    logic        busy_o;

    uart_dbg_bridge #(.TimeoutCycles(50)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .rx_data_i   (rx_data_i),
        .rx_valid_i  (rx_valid_i),
        .rx_ready_o  (rx_ready_o),
        .tx_data_o   (tx_data_o),
        .tx_valid_o  (tx_valid_o),
        .tx_ready_i  (tx_ready_i),
        .obi_req_o   (obi_req_o),
        .obi_we_o    (obi_we_o),
        .obi_addr_o  (obi_addr_o),
        .obi_be_o    (obi_be_o),
        .obi_wdata_o (obi_wdata_o),
        .obi_gnt_i   (obi_gnt_i),
        .obi_rvalid_i(obi_rvalid_i),
        .obi_rdata_i (obi_rdata_i),
        .obi_err_i   (obi_err_i),
        .exec_addr_o (exec_addr_o),
        .exec_valid_o(exec_valid_o),
        .busy_o      (busy_o)
    );

    // 100 MHz-style free-running clock.
    always #5 clk_i = ~clk_i;

    int          vectorCount = 0;
    int          missCount   = 0;
    logic [7:0]  txExp[$];
    logic [68:0] obiExp[$];
    logic [31:0] execExp[$];
    byte_q_t     frame;

    int          gntDelay    = 2;
    int          rvalidDelay = 0;
    logic [31:0] rspData     = 32'h0;
    logic        rspErr      = 1'b0;

    task automatic checkOutput(input string name, input logic [71:0] actual,
                               input logic [71:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic flagFail(input string name, input logic [71:0] actual);
        vectorCount++;
        missCount++;
        $display("[TB] FAIL %s: got %0h, expected no such event", name, actual);
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        int waited = 0;
        bit accepted = 1'b0;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        while (!accepted && waited < 200) begin
            @(negedge clk_i);
            accepted = rx_ready_o;
            @(posedge clk_i);
            #1;
            waited++;
        end
        rx_valid_i = 1'b0;
        if (!accepted) flagFail("rxAcceptTimeout", 72'(b));
    endtask

    task automatic sendBytes(input byte_q_t bytes);
        foreach (bytes[i]) applyStimulus(bytes[i]);
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while ((busy_o || txExp.size() != 0 || obiExp.size() != 0 || execExp.size() != 0)
               && n < 300) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        if (n >= 300) flagFail(name, 72'(txExp.size()));
        else checkOutput(name, 72'(busy_o), 72'(0));
    endtask

    // Scoreboard monitor: compares every tx transfer, OBI grant and exec pulse.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_ni) begin
                if (tx_valid_o && tx_ready_i) begin
                    if (txExp.size() == 0) flagFail("txUnexpected", 72'(tx_data_o));
                    else checkOutput("txByte", 72'(tx_data_o), 72'(txExp.pop_front()));
                end
                if (obi_req_o && obi_gnt_i) begin
                    if (obiExp.size() == 0) flagFail("obiUnexpected", 72'(obi_addr_o));
                    else checkOutput("obiReq",
                                     72'({obi_we_o, obi_be_o, obi_addr_o,
                                          obi_we_o ? obi_wdata_o : 32'h0}),
                                     72'(obiExp.pop_front()));
                end
                if (exec_valid_o) begin
                    if (execExp.size() == 0) flagFail("execUnexpected", 72'(exec_addr_o));
                    else checkOutput("execPulse", 72'(exec_addr_o), 72'(execExp.pop_front()));
                end
            end
        end
    end

    // OBI subordinate model: grant after gntDelay cycles, response rvalidDelay later.
    initial begin
        int  reqAge      = 0;
        int  rspWait     = 0;
        bit  rspPending  = 1'b0;
        obi_gnt_i    = 1'b0;
        obi_rvalid_i = 1'b0;
        obi_rdata_i  = 32'h0;
        obi_err_i    = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            obi_gnt_i    = 1'b0;
            obi_rvalid_i = 1'b0;
            obi_rdata_i  = 32'h0;
            obi_err_i    = 1'b0;
            if (!rst_ni) begin
                rspPending = 1'b0;
                reqAge     = 0;
            end else if (rspPending) begin
                if (rspWait == 0) begin
                    obi_rvalid_i = 1'b1;
                    obi_rdata_i  = rspData;
                    obi_err_i    = rspErr;
                    rspPending   = 1'b0;
                end else begin
                    rspWait--;
                end
            end else if (obi_req_o) begin
                if (reqAge >= gntDelay) begin
                    obi_gnt_i = 1'b1;
                    reqAge    = 0;
                    if (rvalidDelay == 0) begin
                        obi_rvalid_i = 1'b1;
                        obi_rdata_i  = rspData;
                        obi_err_i    = rspErr;
                    end else begin
                        rspPending = 1'b1;
                        rspWait    = rvalidDelay - 1;
                    end
                end else begin
                    reqAge++;
                end
            end
        end
    end

    // Watchdog so a hung DUT still ends the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got hang, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence of command frames.
    initial begin
        int n;
        rst_ni     = 1'b0;
        rx_data_i  = 8'h00;
        rx_valid_i = 1'b0;
        tx_ready_i = 1'b1;
        #1;
        checkOutput("rstRxReady",   72'(rx_ready_o),   72'(1));
        checkOutput("rstTxValid",   72'(tx_valid_o),   72'(0));
        checkOutput("rstTxData",    72'(tx_data_o),    72'(0));
        checkOutput("rstObiReq",    72'(obi_req_o),    72'(0));
        checkOutput("rstExecValid", 72'(exec_valid_o), 72'(0));
        checkOutput("rstExecAddr",  72'(exec_addr_o),  72'(0));
        checkOutput("rstBusy",      72'(busy_o),       72'(0));
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Write with grant and response together after two cycles.
        gntDelay = 2; rvalidDelay = 0; rspErr = 1'b0; rspData = 32'h0;
        obiExp.push_back({1'b1, 4'hF, 32'h1000_0000, 32'h1234_5678});
        txExp.push_back(8'h06);
        frame = {8'h12, 8'h00, 8'h00, 8'h00, 8'h10, 8'h78, 8'h56, 8'h34, 8'h12};
        sendBytes(frame);
        waitIdle("writeDone");

        // Read with a separate response cycle.
        gntDelay = 1; rvalidDelay = 2; rspData = 32'hDEAD_BEEF;
        obiExp.push_back({1'b0, 4'hF, 32'h1000_0000, 32'h0});
        txExp = {8'h06, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        frame = {8'h11, 8'h00, 8'h00, 8'h00, 8'h10};
        sendBytes(frame);
        waitIdle("readDone");

        // Read returning a bus error: NAK only.
        rspErr = 1'b1; rspData = 32'hCAFE_F00D;
        obiExp.push_back({1'b0, 4'hF, 32'h2000_0004, 32'h0});
        txExp.push_back(8'h15);
        frame = {8'h11, 8'h04, 8'h00, 8'h00, 8'h20};
        sendBytes(frame);
        waitIdle("errorDone");
        rspErr = 1'b0;

        // Exec: one start pulse, then ACK.
        execExp.push_back(32'h1000_0080);
        txExp.push_back(8'h06);
        frame = {8'h13, 8'h80, 8'h00, 8'h00, 8'h10};
        sendBytes(frame);
        waitIdle("execDone");
        checkOutput("execAddrAfter", 72'(exec_addr_o), 72'(32'h1000_0080));

        // Abandoned write frame times out silently.
        frame = {8'h12, 8'h00};
        sendBytes(frame);
        checkOutput("timeoutStillBusy", 72'(busy_o), 72'(1));
        repeat (60) @(posedge clk_i);
        #1;
        checkOutput("timeoutIdle",    72'(busy_o),     72'(0));
        checkOutput("timeoutRxReady", 72'(rx_ready_o), 72'(1));
        gntDelay = 0; rvalidDelay = 0; rspData = 32'h0BAD_CAFE;
        obiExp.push_back({1'b0, 4'hF, 32'h1000_0000, 32'h0});
        txExp = {8'h06, 8'hFE, 8'hCA, 8'hAD, 8'h0B};
        frame = {8'h11, 8'h00, 8'h00, 8'h00, 8'h10};
        sendBytes(frame);
        waitIdle("postTimeoutRead");
        checkOutput("execAddrHold", 72'(exec_addr_o), 72'(32'h1000_0080));

        // Backpressure in the data phase, then reset mid-response.
        gntDelay = 1; rvalidDelay = 1; rspData = 32'hDEAD_BEEF;
        obiExp.push_back({1'b0, 4'hF, 32'h1000_0000, 32'h0});
        txExp = {8'h06, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        frame = {8'h11, 8'h00, 8'h00, 8'h00, 8'h10};
        sendBytes(frame);
        n = 0;
        while (txExp.size() != 4 && n < 300) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        if (n >= 300) flagFail("ackBeforeStall", 72'(txExp.size()));
        tx_ready_i = 1'b0;
        repeat (20) @(posedge clk_i);
        #1;
        checkOutput("stallTxValid", 72'(tx_valid_o), 72'(1));
        checkOutput("stallTxData",  72'(tx_data_o),  72'(8'hEF));
        rst_ni = 1'b0;
        #1;
        checkOutput("midRstTxValid",  72'(tx_valid_o),  72'(0));
        checkOutput("midRstBusy",     72'(busy_o),      72'(0));
        checkOutput("midRstRxReady",  72'(rx_ready_o),  72'(1));
        checkOutput("midRstExecAddr", 72'(exec_addr_o), 72'(0));
        txExp.delete();
        @(posedge clk_i);
        #1;
        rst_ni     = 1'b1;
        tx_ready_i = 1'b1;
        frame = {8'h42};
        sendBytes(frame);
        repeat (10) @(posedge clk_i);
        #1;
        checkOutput("unknownIgnoredBusy", 72'(busy_o),     72'(0));
        checkOutput("unknownIgnoredTx",   72'(tx_valid_o), 72'(0));

        checkOutput("txQueueDrained",   72'(txExp.size()),   72'(0));
        checkOutput("obiQueueDrained",  72'(obiExp.size()),  72'(0));
        checkOutput("execQueueDrained", 72'(execExp.size()), 72'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
